// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Bring-up reset sequencer for a bank of bsg_link_sdr channels and their core.
// Steps the link and core resets in order, with a fixed dwell time per step.
module bsg_link_sdr_reset_sequencer #(
   parameter int hold_cycles_p  = 16,
   parameter int token_cycles_p = 8
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       restart_i,
   output logic       uplink_reset_o,
   output logic       downlink_reset_o,
   output logic       downstream_reset_o,
   output logic       token_reset_o,
   output logic       core_reset_o,
   output logic       done_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_ALL   = 3'd0,
      S_TOK   = 3'd1,
      S_TOKW  = 3'd2,
      S_DLINK = 3'd3,
      S_ULINK = 3'd4,
      S_DSTRM = 3'd5,
      S_RUN   = 3'd6
   } state_e;

   localparam int MAXC = (hold_cycles_p > token_cycles_p)
                       ? hold_cycles_p : token_cycles_p;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(hold_cycles_p - 1);
   localparam logic [CW-1:0] TOK_LAST  = CW'(token_cycles_p - 1);

   state_e          r_state;
   state_e          w_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_last;
   logic [5:0]      r_out;

   // {up, dn, ds, tok, core, done}; unknown codes fall back to S_ALL
   function automatic logic [5:0] dec(input state_e s);
      case (s)
         S_TOK:   dec = 6'b111110;
         S_TOKW:  dec = 6'b111010;
         S_DLINK: dec = 6'b101010;
         S_ULINK: dec = 6'b001010;
         S_DSTRM: dec = 6'b000010;
         S_RUN:   dec = 6'b000001;
         default: dec = 6'b111010;
      endcase
   endfunction

   always_comb begin
      w_last = (r_state == S_TOK) ? (r_cnt == TOK_LAST)
                                  : (r_cnt == HOLD_LAST);
      w_nxt  = r_state;
      case (r_state)
         S_ALL:   if (w_last) w_nxt = S_TOK;
         S_TOK:   if (w_last) w_nxt = S_TOKW;
         S_TOKW:  if (w_last) w_nxt = S_DLINK;
         S_DLINK: if (w_last) w_nxt = S_ULINK;
         S_ULINK: if (w_last) w_nxt = S_DSTRM;
         S_DSTRM: if (w_last) w_nxt = S_RUN;
         S_RUN:   if (restart_i) w_nxt = S_ALL;
         default: w_nxt = S_ALL;
      endcase
      // Counter restarts on every state entry and idles at zero in S_RUN
      if ((w_nxt != r_state) || (r_state == S_RUN))
         w_cnt_nxt = '0;
      else
         w_cnt_nxt = r_cnt + CW'(1);
   end

   // Outputs are registered from the next state to stay glitch-free
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state <= S_ALL;
         r_cnt   <= '0;
         r_out   <= dec(S_ALL);
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= dec(w_nxt);
      end
   end

   assign uplink_reset_o     = r_out[5];
   assign downlink_reset_o   = r_out[4];
   assign downstream_reset_o = r_out[3];
   assign token_reset_o      = r_out[2];
   assign core_reset_o       = r_out[1];
   assign done_o             = r_out[0];
   assign state_o            = r_state;

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Directed bench for the link reset sequencer.
// Runs an H=4/T=2 instance and an H=1/T=1 instance side by side.
module tb_bsg_link_sdr_reset_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   logic rs;
   logic rs1;

   logic       up4, dn4, ds4, tk4, co4, dn_4;
   logic [2:0] st4;
   logic       up1, dn1, ds1, tk1, co1, dn_1;
   logic [2:0] st1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         s4;
      int         s1;
      logic [2:0] st;
      logic [5:0] o;
   } seg_t;

   seg_t tbl [7];

   always #5 clk = ~clk;

   bsg_link_sdr_reset_sequencer #(
      .hold_cycles_p(4), .token_cycles_p(2)
   ) u_big (
      .clk_i(clk), .reset_n_i(rst_n), .restart_i(rs),
      .uplink_reset_o(up4), .downlink_reset_o(dn4),
      .downstream_reset_o(ds4), .token_reset_o(tk4),
      .core_reset_o(co4), .done_o(dn_4), .state_o(st4)
   );

   bsg_link_sdr_reset_sequencer #(
      .hold_cycles_p(1), .token_cycles_p(1)
   ) u_small (
      .clk_i(clk), .reset_n_i(rst_n), .restart_i(rs1),
      .uplink_reset_o(up1), .downlink_reset_o(dn1),
      .downstream_reset_o(ds1), .token_reset_o(tk1),
      .core_reset_o(co1), .done_o(dn_1), .state_o(st1)
   );

   task automatic cmp(input string nm, input int c,
                      input logic [5:0] got, input logic [5:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, got, exp);
      end
   endtask

   function automatic void exp_at(input int c, input bit sm,
                                  output logic [2:0] st,
                                  output logic [5:0] o);
      st = 3'd0;
      o  = 6'b111010;
      for (int i = 0; i < 7; i++) begin
         if (c >= (sm ? tbl[i].s1 : tbl[i].s4)) begin
            st = tbl[i].st;
            o  = tbl[i].o;
         end
      end
   endfunction

   task automatic check_cyc(input int c);
      logic [2:0] st;
      logic [5:0] o;
      exp_at(c, 1'b0, st, o);
      cmp("big_out", c, {up4, dn4, ds4, tk4, co4, dn_4}, o);
      cmp("big_state", c, {3'b0, st4}, {3'b0, st});
      exp_at(c, 1'b1, st, o);
      cmp("small_out", c, {up1, dn1, ds1, tk1, co1, dn_1}, o);
      cmp("small_state", c, {3'b0, st1}, {3'b0, st});
   endtask

   task automatic check_seq(input int n, input int lo, input int hi);
      for (int c = 0; c < n; c++) begin
         rs = (c >= lo) && (c <= hi);
         check_cyc(c);
         @(negedge clk);
      end
      rs = 1'b0;
   endtask

   initial begin
      tbl[0] = '{s4: 0,  s1: 0, st: 3'd0, o: 6'b111010};
      tbl[1] = '{s4: 4,  s1: 1, st: 3'd1, o: 6'b111110};
      tbl[2] = '{s4: 6,  s1: 2, st: 3'd2, o: 6'b111010};
      tbl[3] = '{s4: 10, s1: 3, st: 3'd3, o: 6'b101010};
      tbl[4] = '{s4: 14, s1: 4, st: 3'd4, o: 6'b001010};
      tbl[5] = '{s4: 18, s1: 5, st: 3'd5, o: 6'b000010};
      tbl[6] = '{s4: 22, s1: 6, st: 3'd6, o: 6'b000001};

      rst_n = 1'b0;
      rs    = 1'b0;
      rs1   = 1'b0;

      // held in reset for three edges
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_cyc(0);
      end
      rst_n = 1'b1;

      // full bring-up, then a few cycles of S_RUN
      check_seq(26, -1, -1);

      // single-cycle restart from S_RUN on both instances
      rs  = 1'b1;
      rs1 = 1'b1;
      @(negedge clk);
      rs  = 1'b0;
      rs1 = 1'b0;
      check_seq(26, -1, -1);

      // restart held through the timed states must be ignored
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_seq(30, 5, 21);

      // reset mid-sequence in S_ULINK at cnt=2
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_seq(16, -1, -1);
      check_cyc(16);
      rst_n = 1'b0;
      @(negedge clk);
      check_cyc(0);
      rst_n = 1'b1;
      check_seq(25, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
